// File: rtl/perfcnt_bank.sv
// Per-thread 64-bit performance counter bank.
// Event pulses increment enabled counters, control writes clear counters or
// load per-thread enable masks, and IO reads return a counter value with a
// fixed two-cycle latency through a one-entry request register.

package perfcnt_pkg;
  localparam int NTHREADIDMSB = 2;
  localparam int ADDR_W       = 8;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [NTHREADIDMSB:0] tid;
    logic                  req;
  } perf_count_read_req_in_t;

  typedef struct packed {
    logic [63:0] data;
    logic        valid;
  } perf_count_read_req_out_t;

  typedef struct packed {
    logic [31:0]           inst;
    logic [NTHREADIDMSB:0] tid;
    logic                  valid;
  } perf_count_write_req_in_t;
endpackage

module perfcnt_bank
  import perfcnt_pkg::*;
#(
  parameter int NTHREAD = 8,
  parameter int NCNT    = 8
) (
  input  logic                      gclk,
  input  logic                      rst,
  input  perf_count_read_req_in_t   rd_req,
  output perf_count_read_req_out_t  rd_resp,
  input  perf_count_write_req_in_t  wr_req,
  input  logic                      evt_valid,
  input  logic [NTHREADIDMSB:0]     evt_tid,
  input  logic [NCNT-1:0]           evt_mask,
  output logic [NTHREAD*NCNT-1:0]   cnt_en
);

  localparam int CIDX  = $clog2(NCNT);
  localparam int NTOT  = NTHREAD * NCNT;
  localparam int SEL_W = $clog2(NTOT);

  // Stage-1 read request: what to read and whether the address is legal.
  typedef struct packed {
    logic                  req;
    logic                  oob;
    logic [NTHREADIDMSB:0] tid;
    logic [CIDX-1:0]       idx;
  } perf_count_read_reg_t;

  logic [63:0]          cnt_q [NTOT];
  logic [NTOT-1:0]      en_q, en_d;
  logic [NTOT-1:0]      clr_mask, inc_mask;
  perf_count_read_reg_t perf_count_read_reg_q, perf_count_read_reg_d;
  perf_count_read_req_out_t rd_resp_q, rd_resp_d;
  logic [SEL_W-1:0]     rd_sel;

  // Decode writes and events into per-counter clear/increment strobes and the next enable mask.
  always_comb begin
    clr_mask = '0;
    inc_mask = '0;
    en_d     = en_q;
    for (int k = 0; k < NTOT; k++) begin
      if (wr_req.valid && (int'(wr_req.tid) == k / NCNT)) begin
        case (wr_req.inst[31:30])
          2'b01: if (int'(wr_req.inst[CIDX-1:0]) == k % NCNT) clr_mask[k] = 1'b1;
          2'b10: en_d[k] = wr_req.inst[16 + (k % NCNT)];
          2'b11: clr_mask[k] = 1'b1;
          default: ;
        endcase
      end
      // Events see the enable mask as it stood before any write in this cycle.
      if (evt_valid && (int'(evt_tid) == k / NCNT)) begin
        inc_mask[k] = evt_mask[k % NCNT] & en_q[k];
      end
    end
  end

  // Counter storage: clear wins over increment; increments wrap modulo 2^64.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NTOT; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NTOT; k++) begin
        if (clr_mask[k])      cnt_q[k] <= '0;
        else if (inc_mask[k]) cnt_q[k] <= cnt_q[k] + 64'd1;
      end
    end
  end

  // Enable mask register.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) en_q <= '0;
    else     en_q <= en_d;
  end

  // Capture the incoming read request; any nonzero address bit above the index marks it out of range.
  always_comb begin
    perf_count_read_reg_d.req = rd_req.req;
    perf_count_read_reg_d.tid = rd_req.tid;
    perf_count_read_reg_d.idx = rd_req.addr[CIDX:1];
    perf_count_read_reg_d.oob = (|(rd_req.addr >> (CIDX + 1))) || (int'(rd_req.tid) >= NTHREAD);
  end

  // Stage-1 request register; cleared by reset so an in-flight read is dropped.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) perf_count_read_reg_q <= '0;
    else     perf_count_read_reg_q <= perf_count_read_reg_d;
  end

  assign rd_sel = SEL_W'(int'(perf_count_read_reg_q.tid) * NCNT + int'(perf_count_read_reg_q.idx));

  // Build the response: the full 64-bit value, zero when out of range, data held while idle.
  always_comb begin
    rd_resp_d       = rd_resp_q;
    rd_resp_d.valid = perf_count_read_reg_q.req;
    if (perf_count_read_reg_q.req) begin
      rd_resp_d.data = perf_count_read_reg_q.oob ? 64'd0 : cnt_q[rd_sel];
    end
  end

  // Response register.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) rd_resp_q <= '0;
    else     rd_resp_q <= rd_resp_d;
  end

  assign rd_resp = rd_resp_q;
  assign cnt_en  = en_q;

endmodule

// File: tb/tb_perfcnt_bank.sv
// Scoreboard bench for perfcnt_bank: a reference model computes each read's
// expected value when the request is driven; a monitor pops and compares
// every response as it appears.

module tb_perfcnt_bank;
  import perfcnt_pkg::*;

  logic                     gclk;
  logic                     rst;
  perf_count_read_req_in_t  rd_req;
  perf_count_read_req_out_t rd_resp;
  perf_count_write_req_in_t wr_req;
  logic                     evt_valid;
  logic [2:0]               evt_tid;
  logic [7:0]               evt_mask;
  logic [63:0]              cnt_en;

  perfcnt_bank #(.NTHREAD(8), .NCNT(8)) dut (
    .gclk      (gclk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_resp   (rd_resp),
    .wr_req    (wr_req),
    .evt_valid (evt_valid),
    .evt_tid   (evt_tid),
    .evt_mask  (evt_mask),
    .cnt_en    (cnt_en)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic [63:0] m_cnt [8][8];
  logic [7:0]  m_en  [8];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 8; t++) begin
      m_en[t] = '0;
      for (int i = 0; i < 8; i++) m_cnt[t][i] = '0;
    end
    sb_q.delete();
  endtask

  function automatic logic [63:0] exp_en();
    logic [63:0] v;
    for (int t = 0; t < 8; t++) v[t*8 +: 8] = m_en[t];
    return v;
  endfunction

  // One clock cycle of stimulus, started and ended at a falling edge.
  task automatic drive(input logic ev, input logic [2:0] et, input logic [7:0] em,
                       input logic wv, input logic [2:0] wt, input logic [31:0] wi,
                       input logic rv, input logic [2:0] rt, input logic [7:0] ra);
    logic [7:0] old_en;
    logic [7:0] clrm;
    exp_t       e;
    evt_valid = ev; evt_tid = et; evt_mask = em;
    wr_req.valid = wv; wr_req.tid = wt; wr_req.inst = wi;
    rd_req.req = rv; rd_req.tid = rt; rd_req.addr = ra;
    old_en = m_en[et];
    clrm = '0;
    if (ev) begin
      for (int i = 0; i < 8; i++) if (em[i] && old_en[i]) m_cnt[et][i] = m_cnt[et][i] + 64'd1;
    end
    if (wv) begin
      case (wi[31:30])
        2'b01: clrm[wi[2:0]] = 1'b1;
        2'b10: m_en[wt] = wi[23:16];
        2'b11: clrm = 8'hFF;
        default: ;
      endcase
      for (int i = 0; i < 8; i++) if (clrm[i]) m_cnt[wt][i] = '0;
    end
    if (rv) begin
      e.due  = cyc + 2;
      e.data = (ra[7:4] != 4'd0) ? 64'd0 : m_cnt[rt][ra[3:1]];
      sb_q.push_back(e);
    end
    @(posedge gclk);
    @(negedge gclk);
    evt_valid = 1'b0; wr_req = '0; rd_req = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic evt(input logic [2:0] t, input logic [7:0] m);
    drive(1, t, m, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] t, input logic [31:0] inst);
    drive(0, 0, 0, 1, t, inst, 0, 0, 0);
  endtask

  task automatic rd(input logic [2:0] t, input logic [7:0] addr);
    drive(0, 0, 0, 0, 0, 0, 1, t, addr);
  endtask

  // Response monitor: every valid response must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge gclk);
      cyc++;
      #1;
      if (!rst && rd_resp.valid) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          $display("[TB] rd resp cyc=%0d data=0x%016h exp=0x%016h", cyc, rd_resp.data, e.data);
          check_val("rd_latency", 64'(cyc), 64'(e.due));
          check_val("rd_data", rd_resp.data, e.data);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    evt_valid = 1'b0; evt_tid = '0; evt_mask = '0;
    wr_req = '0; rd_req = '0;
    model_reset();
    repeat (3) @(negedge gclk);
    check_val("rst_valid", 64'(rd_resp.valid), 64'd0);
    check_val("rst_data", rd_resp.data, 64'd0);
    check_val("rst_cnt_en", cnt_en, 64'd0);
    rst = 1'b0;
    idle(1);

    // 1: enable all of tid2, five events on counter 0, read it back.
    wr(2, 32'h80FF_0000);
    check_val("cnt_en_tid2", cnt_en, exp_en());
    for (int i = 0; i < 5; i++) evt(2, 8'h01);
    rd(2, 8'h00);
    idle(3);

    // 2: preloaded counter wraps through zero.
    dut.cnt_q[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    m_cnt[0][3]  = 64'hFFFF_FFFF_FFFF_FFFE;
    wr(0, 32'h8008_0000);
    for (int i = 0; i < 3; i++) evt(0, 8'h08);
    rd(0, 8'h06);
    idle(3);

    // 3: clear and increment on the same counter in one cycle.
    wr(1, 32'h80FF_0000);
    evt(1, 8'h01);
    evt(1, 8'h01);
    drive(1, 1, 8'h01, 1, 1, 32'h4000_0000, 1, 1, 8'h00);
    rd(1, 8'h00);
    idle(3);

    // 4: read in the same cycle as an event, then back-to-back reads under traffic.
    wr(3, 32'h800F_0000);
    drive(1, 3, 8'h01, 0, 0, 0, 1, 3, 8'h00);
    for (int k = 0; k < 4; k++) drive(1, 3, 8'h0F, 0, 0, 0, 1, 3, 8'(k * 2));
    rd(3, 8'h03);
    rd(3, 8'h10);
    rd(3, 8'h80);
    idle(3);

    // Enable write and event in one cycle: the old (zero) enable applies.
    drive(1, 5, 8'hFF, 1, 5, 32'h80FF_0000, 0, 0, 0);
    evt(5, 8'h01);
    rd(5, 8'h00);
    rd(5, 8'h02);
    idle(3);

    // 5: single enabled counter under full event mask, then clear-all.
    wr(4, 32'h8001_0000);
    for (int i = 0; i < 10; i++) evt(4, 8'hFF);
    for (int k = 0; k < 8; k++) rd(4, 8'(k * 2));
    wr(4, 32'hC000_0000);
    for (int k = 0; k < 8; k++) rd(4, 8'(k * 2));
    idle(3);
    check_val("cnt_en_all", cnt_en, exp_en());

    // 6: reset one cycle after a read request drops the response.
    rd(2, 8'h00);
    rst = 1'b1;
    model_reset();
    #1;
    check_val("rst6_valid", 64'(rd_resp.valid), 64'd0);
    check_val("rst6_data", rd_resp.data, 64'd0);
    check_val("rst6_cnt_en", cnt_en, 64'd0);
    @(negedge gclk);
    rst = 1'b0;
    idle(4);
    check_val("post_rst_valid", 64'(rd_resp.valid), 64'd0);
    rd(2, 8'h00);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge gclk);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
